// File: rtl/fp_scan_pkg.sv
// rtl/fp_scan_pkg.sv - shared state encodings and constants for the front-panel scanner
package fp_scan_pkg;

  // Slot phases; encodings are fixed so panel debug tools can decode them.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    GAP    = 2'd3
  } fp_state_e;

  // Byte returned for a host read of a unit that does not exist.
  localparam logic [7:0] OOR_DATA = 8'hFF;

  // Unit-address width: clog2 of the unit count, never below one bit.
  function automatic int addr_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fp_scan_if.sv
// rtl/fp_scan_if.sv - host (debug) single-byte read port of the front-panel scanner
interface fp_scan_if #(parameter int AW = 1);
  logic          host_req;
  logic [AW-1:0] host_addr;
  logic          host_ack;
  logic [7:0]    host_data;

  modport master (output host_req, host_addr, input host_ack, host_data);
  modport slave  (input host_req, host_addr, output host_ack, host_data);
endinterface

// File: rtl/fp_slot_timer.sv
// rtl/fp_slot_timer.sv - loadable 8-bit down-counter timing the strobe dwell
module fp_slot_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       dec_i,
  output logic       done_o
);

  logic [7:0] count_q, count_d;

  // Load wins over decrement; the count parks at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == 8'd0);

endmodule

// File: rtl/fp_scan.sv
// rtl/fp_scan.sv - front-panel strobe scanner/arbiter; FP_DOUBLE_SAMPLE_EN enables sample-twice-and-repeat
module fp_scan
  import fp_scan_pkg::*;
#(
  parameter int NUM_UNITS = 2,
  parameter int DWELL     = 4,
  parameter int AW        = addr_width(NUM_UNITS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   scan_en,
  input  logic [7:0]             fpd,
  output logic [NUM_UNITS-1:0]   nfpstb,
  output logic [8*NUM_UNITS-1:0] lights,
  output logic                   frame,
  fp_scan_if.slave               host
);

  localparam logic [AW:0] LAST_UNIT = (AW+1)'(NUM_UNITS - 1);

  fp_state_e              state_q, state_d;
  logic [AW-1:0]          ptr_q, ptr_d;
  logic [AW-1:0]          tgt_q, tgt_d;
  logic                   is_host_q, is_host_d;
  logic                   last_host_q, last_host_d;
  logic                   armed_q, armed_d;
  logic                   retry_q, retry_d;
  logic [8*NUM_UNITS-1:0] lights_q, lights_d;
  logic [7:0]             host_data_q, host_data_d;
  logic                   ack_q, ack_d;
  logic                   frame_q, frame_d;
  logic [NUM_UNITS-1:0]   nfpstb_q, nfpstb_d;

  logic tmr_done;
  logic host_pend;
  logic tgt_oor;
  logic mismatch;

  fp_slot_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (state_q == SETUP),
    .load_val_i (8'(DWELL - 1)),
    .dec_i      (state_q == STROBE),
    .done_o     (tmr_done)
  );

  // A held request only counts once it has been low since the last host slot started.
  assign host_pend = host.host_req && armed_q;
  assign tgt_oor   = ({1'b0, tgt_q} > LAST_UNIT);

`ifdef FP_DOUBLE_SAMPLE_EN
  logic [7:0] samp_q;

  // Shifts fpd every strobe edge, so at the last edge it holds the second-to-last sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp_q <= 8'h00;
    end else if (state_q == STROBE) begin
      samp_q <= fpd;
    end
  end

  // Undriven bus on an out-of-range read is not a disagreement.
  assign mismatch = !tgt_oor && (samp_q != fpd);
`else
  assign mismatch = 1'b0;
`endif

  // Slot sequencing, arbitration and capture of the sampled byte.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    tgt_d       = tgt_q;
    is_host_d   = is_host_q;
    last_host_d = last_host_q;
    retry_d     = retry_q;
    armed_d     = host.host_req ? armed_q : 1'b1;
    lights_d    = lights_q;
    host_data_d = host_data_q;
    ack_d       = 1'b0;
    frame_d     = 1'b0;

    case (state_q)
      IDLE, GAP: begin
        state_d = IDLE;
        if (retry_q) begin
          // Repeat the same slot without re-arbitrating, so fairness is untouched.
          state_d = SETUP;
        end else if (host_pend && (!last_host_q || !scan_en)) begin
          state_d     = SETUP;
          tgt_d       = host.host_addr;
          is_host_d   = 1'b1;
          last_host_d = 1'b1;
          armed_d     = 1'b0;
        end else if (scan_en) begin
          state_d     = SETUP;
          tgt_d       = ptr_q;
          is_host_d   = 1'b0;
          last_host_d = 1'b0;
        end
      end
      SETUP: begin
        state_d = STROBE;
      end
      STROBE: begin
        if (tmr_done) begin
          state_d = GAP;
          if (mismatch && !retry_q) begin
            retry_d = 1'b1;
          end else begin
            retry_d = 1'b0;
            if (!mismatch) begin
              for (int k = 0; k < NUM_UNITS; k++) begin
                if (tgt_q == AW'(k)) begin
                  lights_d[8*k +: 8] = fpd;
                end
              end
            end
            if (is_host_q) begin
              host_data_d = tgt_oor ? OOR_DATA : fpd;
              ack_d       = 1'b1;
            end else begin
              ptr_d   = ({1'b0, ptr_q} == LAST_UNIT) ? '0 : ptr_q + 1'b1;
              frame_d = ({1'b0, ptr_q} == LAST_UNIT);
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Strobe follows the next state so it is a clean register output; no match when out of range.
    nfpstb_d = '1;
    if (state_d == STROBE) begin
      for (int k = 0; k < NUM_UNITS; k++) begin
        if (tgt_d == AW'(k)) begin
          nfpstb_d[k] = 1'b0;
        end
      end
    end
  end

  // State and datapath registers; reset releases the strobes immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      tgt_q       <= '0;
      is_host_q   <= 1'b0;
      last_host_q <= 1'b0;
      armed_q     <= 1'b1;
      retry_q     <= 1'b0;
      lights_q    <= '0;
      host_data_q <= 8'h00;
      ack_q       <= 1'b0;
      frame_q     <= 1'b0;
      nfpstb_q    <= '1;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      tgt_q       <= tgt_d;
      is_host_q   <= is_host_d;
      last_host_q <= last_host_d;
      armed_q     <= armed_d;
      retry_q     <= retry_d;
      lights_q    <= lights_d;
      host_data_q <= host_data_d;
      ack_q       <= ack_d;
      frame_q     <= frame_d;
      nfpstb_q    <= nfpstb_d;
    end
  end

  assign nfpstb         = nfpstb_q;
  assign lights         = lights_q;
  assign frame          = frame_q;
  assign host.host_ack  = ack_q;
  assign host.host_data = host_data_q;

endmodule

// File: tb/tb_fp_scan.sv
// tb/tb_fp_scan.sv - scoreboard bench for fp_scan (2 units, dwell 4, 2-bit host address)
module tb_fp_scan;

  localparam int DW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        scan_en;
  logic [7:0]  fpd;
  logic [1:0]  nfpstb;
  logic [15:0] lights;
  logic        frame;
  logic        glitch = 1'b0;
  int          low_cnt = 0;

  always #5 clk = ~clk;

  fp_scan_if #(.AW(2)) hif ();

  fp_scan #(.NUM_UNITS(2), .DWELL(DW), .AW(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .scan_en (scan_en),
    .fpd     (fpd),
    .nfpstb  (nfpstb),
    .lights  (lights),
    .frame   (frame),
    .host    (hif)
  );

  always @(posedge clk) low_cnt <= (nfpstb != 2'b11) ? low_cnt + 1 : 0;

  always_comb begin
    if (!nfpstb[0])      fpd = 8'h34;
    else if (!nfpstb[1]) fpd = 8'h12;
    else                 fpd = 8'h5A;
    if (glitch && (nfpstb != 2'b11) && (low_cnt == DW - 1)) fpd = 8'hAA;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  logic [7:0] exp_ack_q[$];
  int         stb_cnt[2];
  int         stb_log[$];

  initial begin : ack_monitor
    logic prev_ack;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && hif.host_ack) begin
        check("ack_one_cycle", prev_ack, 0);
        check("ack_expected", exp_ack_q.size() > 0, 1);
        if (exp_ack_q.size() > 0) check("host_data", hif.host_data, exp_ack_q.pop_front());
      end
      prev_ack = hif.host_ack;
    end
  end

  initial begin : strobe_monitor
    int cur_len, gap_len, cur_unit;
    logic [1:0] prev;
    cur_len = 0; gap_len = 99; cur_unit = 0; prev = 2'b11;
    forever begin
      @(negedge clk);
      if (reset) begin
        cur_len = 0; gap_len = 99; prev = 2'b11;
      end else begin
        if (nfpstb != 2'b11) begin
          if (prev == 2'b11) begin
            check("stb_gap_ge2", gap_len >= 2, 1);
            cur_unit = nfpstb[0] ? 1 : 0;
          end else begin
            check("stb_steady", nfpstb, prev);
          end
          cur_len++;
        end else begin
          if (prev != 2'b11) begin
            check("stb_width", cur_len, DW);
            stb_cnt[cur_unit]++;
            stb_log.push_back(cur_unit);
            cur_len = 0;
            gap_len = 0;
          end
          gap_len++;
        end
        prev = nfpstb;
      end
    end
  end

  task automatic host_read(input logic [1:0] addr, input logic [7:0] exp, output int lat);
    exp_ack_q.push_back(exp);
    hif.host_addr = addr;
    hif.host_req  = 1'b1;
    lat = 0;
    @(negedge clk);
    while (!hif.host_ack && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("host_ack_seen", hif.host_ack, 1);
    hif.host_req = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    int lat, n, c0, c1, nfr;
    logic [1:0] tbl [12];
    int exp_log [6];

    reset = 1'b1; scan_en = 1'b0; hif.host_req = 1'b0; hif.host_addr = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_nfpstb", nfpstb, 2'b11);
    check("rst_lights", lights, 16'h0000);
    check("rst_host_data", hif.host_data, 8'h00);
    check("rst_host_ack", hif.host_ack, 0);
    check("rst_frame", frame, 0);

    // Background scan from reset.
    @(posedge clk); #1; reset = 1'b0; scan_en = 1'b1;
    tbl = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("scan_seq[%0d]", i), nfpstb, tbl[i]);
    end
    @(negedge clk);
    check("scan_lights", lights, 16'h1234);
    check("scan_frame_first", frame, 1);
    nfr = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      nfr += int'(frame);
    end
    check("scan_frame_period_last", frame, 1);
    check("scan_frame_count", nfr, 1);
    @(posedge clk); #1; scan_en = 1'b0;
    repeat (10) @(posedge clk); #1;

    // Host read in idle.
    c0 = stb_cnt[0]; c1 = stb_cnt[1];
    host_read(2'd1, 8'h12, lat);
    check("host_lat_idle", lat, DW + 2);
    repeat (2) @(negedge clk);
    check("host_one_pulse_u1", stb_cnt[1] - c1, 1);
    check("host_no_pulse_u0", stb_cnt[0] - c0, 0);

    // Host and scan both requesting: slots alternate.
    @(posedge clk); #1;
    stb_log.delete();
    scan_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      host_read(2'd0, 8'h34, lat);
      check($sformatf("alt_lat[%0d]", r), lat, (r == 0) ? 2 * (DW + 2) : 2 * (DW + 2) - 1);
      if (r == 2) scan_en = 1'b0;
      @(posedge clk); #1;
    end
    repeat (3) @(negedge clk);
    exp_log = '{1, 0, 0, 0, 1, 0};
    check("alt_slot_count", stb_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < stb_log.size()) check($sformatf("alt_slot[%0d]", i), stb_log[i], exp_log[i]);
    end
    check("alt_lights", lights, 16'h1234);

    // Out-of-range host address.
    @(posedge clk); #1;
    c0 = stb_cnt[0]; c1 = stb_cnt[1];
    host_read(2'd3, 8'hFF, lat);
    check("oor_lat", lat, DW + 2);
    repeat (2) @(negedge clk);
    check("oor_no_strobe", (stb_cnt[0] - c0) + (stb_cnt[1] - c1), 0);
    check("oor_lights", lights, 16'h1234);

    // A request still high after its ack is stale.
    @(posedge clk); #1;
    host_read(2'd0, 8'h34, lat);
    hif.host_req = 1'b1;
    c0 = stb_cnt[0];
    repeat (15) @(negedge clk);
    check("stale_no_slot", stb_cnt[0] - c0, 0);
    @(posedge clk); #1; hif.host_req = 1'b0;
    @(posedge clk); #1;
    host_read(2'd0, 8'h34, lat);
    check("rereq_lat", lat, DW + 2);

    // Reset in the 2nd strobe cycle of a unit-1 scan slot.
    @(posedge clk); #1; scan_en = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (nfpstb != 2'b01 && n < 40);
    check("pre_reset_u1_strobe", nfpstb, 2'b01);
    @(posedge clk); #2; reset = 1'b1; #1;
    check("rst_mid_nfpstb", nfpstb, 2'b11);
    check("rst_mid_lights", lights, 16'h0000);
    check("rst_mid_host_data", hif.host_data, 8'h00);
    check("rst_mid_ack", hif.host_ack, 0);
    check("rst_mid_frame", frame, 0);
    @(posedge clk); #1; reset = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (nfpstb == 2'b11 && n < 40);
    check("post_reset_first_unit", nfpstb, 2'b10);
    scan_en = 1'b0;
    repeat (12) @(negedge clk);
    check("post_reset_lights", lights, 16'h0034);

`ifdef FP_DOUBLE_SAMPLE_EN
    // Bus changes between the two samples on both attempts.
    @(posedge clk); #1;
    glitch = 1'b1;
    c0 = stb_cnt[0];
    host_read(2'd0, 8'hAA, lat);
    glitch = 1'b0;
    check("dbl_lat", lat, 2 * (DW + 2));
    repeat (2) @(negedge clk);
    check("dbl_two_pulses", stb_cnt[0] - c0, 2);
    check("dbl_lights_kept", lights, 16'h0034);
`endif

    repeat (2) @(negedge clk);
    check("ack_queue_drained", exp_ack_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
